instr_fetch_unit: RTL and testbench

Per-core instruction fetch initiator for the 16-core processor: drives one read port of the shared instruction memory (control code, address), captures the returned word, gathers the immediate word for two-word opcodes, and hands a complete instruction to the core's decode stage over a valid/ready handshake. Owns the core's program counter, accepts jump redirects from the core, and halts on END.

---
 rtl/instr_fetch_unit_pkg.sv | 12 +
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: opcodes, memory control codes, FSM states and decode helper for instruction fetch
package instr_fetch_unit_pkg;
    localparam logic [3:0] OP_END  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd4;
    localparam logic [3:0] OP_JMPZ = 4'd15;
    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_READ = 2'd1;
    typedef enum logic [2:0] {IDLE, REQ_OP, WAIT_OP, REQ_IMM, WAIT_IMM, PRESENT, HALT} state_t;
    function automatic logic needs_imm(input logic [3:0] op);
        return op == OP_LOAD || op == OP_JMPZ;
    endfunction
endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: per-core fetch FSM that reads opcode and optional immediate words and presents complete instructions
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic [1:0]        mem_control,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_word,
    output logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);
    state_t state, nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic redirect;
    logic req_nxt;

    assign redirect = redirect_valid && state != IDLE && state != HALT;
    assign req_nxt = nxt == REQ_OP || nxt == REQ_IMM;

    // next state and PC; a redirect overrides every other transition and drops any partial bundle
    always_comb begin
        nxt = state;
        pc_nxt = pc;
        if (redirect) begin
            nxt = REQ_OP;
            pc_nxt = redirect_pc;
        end else begin
            case (state)
                IDLE:     nxt = run ? REQ_OP : IDLE;
                REQ_OP:   nxt = WAIT_OP;
                WAIT_OP: begin
                    pc_nxt = pc + ADDR_W'(1);
                    nxt = needs_imm(mem_data[13:10]) ? REQ_IMM : PRESENT;
                end
                REQ_IMM:  nxt = WAIT_IMM;
                WAIT_IMM: begin
                    pc_nxt = pc + ADDR_W'(1);
                    nxt = PRESENT;
                end
                PRESENT:  nxt = instr_ready ? (instr_word[13:10] == OP_END ? HALT : REQ_OP) : PRESENT;
                default:  nxt = state;
            endcase
        end
    end

    // state, PC, Moore outputs registered from the next state, and bundle capture from memory
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            mem_control <= MEM_IDLE;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            instr_word  <= '0;
            instr_imm   <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
        end else begin
            state       <= nxt;
            pc          <= pc_nxt;
            mem_control <= req_nxt ? MEM_READ : MEM_IDLE;
            instr_valid <= nxt == PRESENT;
            halted      <= nxt == HALT;
            if (req_nxt) mem_addr <= pc_nxt;
            if (!redirect && state == WAIT_OP) begin
                instr_word <= mem_data;
                instr_pc   <= pc;
                instr_imm  <= '0;
            end
            if (!redirect && state == WAIT_IMM) instr_imm <= mem_data;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of the fetch unit against a transaction-level model
module tb_instr_fetch_unit;
    logic        clock, reset, run, run_b;
    logic [1:0]  mem_control, mem_control_b;
    logic [15:0] mem_addr, mem_addr_b, mem_data, mem_data_b;
    logic        instr_valid, instr_valid_b, instr_ready, instr_ready_b;
    logic [15:0] instr_word, instr_word_b, instr_imm, instr_imm_b, instr_pc, instr_pc_b;
    logic        redirect_valid, redirect_valid_b, halted, halted_b;
    logic [15:0] redirect_pc, redirect_pc_b;
    logic [15:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    instr_fetch_unit u_dut (
        .clock(clock), .reset(reset), .run(run),
        .mem_control(mem_control), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_word(instr_word), .instr_imm(instr_imm), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_b (
        .clock(clock), .reset(reset), .run(run_b),
        .mem_control(mem_control_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
        .instr_word(instr_word_b), .instr_imm(instr_imm_b), .instr_pc(instr_pc_b),
        .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b), .halted(halted_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous-read instruction memory shared by both fetch units
    always @(posedge clock) begin
        if (mem_control == 2'd1) mem_data <= mem[mem_addr];
        if (mem_control_b == 2'd1) mem_data_b <= mem[mem_addr_b];
    end

    // memory control must only ever be idle or read
    always @(negedge clock) begin
        checks++;
        assert (mem_control <= 2'd1 && mem_control_b <= 2'd1) else begin
            errors++;
            $error("FAIL mem_ctl_range observed=%0d/%0d expected<=1", mem_control, mem_control_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [15:0] w, mpc, ew, ei, rpc;
        logic need, redir;
        int wt;
        reset = 1; run = 0; run_b = 0; instr_ready = 0; instr_ready_b = 0;
        redirect_valid = 0; redirect_pc = 0; redirect_valid_b = 0; redirect_pc_b = 0;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[13:10] == 4'd1) w[13:10] = 4'd2;
            mem[i] = w;
        end
        mem[0] = 16'd2079; mem[1] = 16'd4097; mem[2] = 16'd0; mem[3] = 16'h0805; mem[4] = 16'h0C00;
        mem[51] = 16'd15360; mem[52] = 16'd32; mem[32] = 16'd4097; mem[33] = 16'h1234;
        mem[10] = 16'h0805; mem[61] = 16'd1024; mem[16'hFFFF] = 16'h0805;
        cyc(2);
        chk("rst_ctl", mem_control, 0); chk("rst_addr", mem_addr, 0); chk("rst_valid", instr_valid, 0);
        chk("rst_word", instr_word, 0); chk("rst_imm", instr_imm, 0); chk("rst_pc", instr_pc, 0);
        chk("rst_halted", halted, 0); chk("rst_b_addr", mem_addr_b, 0);
        reset = 0; run = 1;
        cyc(1);
        chk("rst_op_ctl", mem_control, 1); chk("rst_op_addr", mem_addr, 0);
        cyc(1);
        chk("rst_op_wait_ctl", mem_control, 0); chk("rst_op_wait_valid", instr_valid, 0);
        cyc(1);
        chk("rst_op_valid", instr_valid, 1); chk("rst_op_word", instr_word, 2079);
        chk("rst_op_imm", instr_imm, 0); chk("rst_op_pc", instr_pc, 0);
        instr_ready = 1;
        cyc(1);
        instr_ready = 0;
        chk("load_req_ctl", mem_control, 1); chk("load_req_addr", mem_addr, 1);
        cyc(2);
        chk("load_imm_ctl", mem_control, 1); chk("load_imm_addr", mem_addr, 2);
        cyc(2);
        chk("load_valid", instr_valid, 1); chk("load_word", instr_word, 4097);
        chk("load_imm", instr_imm, 0); chk("load_pc", instr_pc, 1);
        instr_ready = 1;
        cyc(1);
        instr_ready = 0;
        chk("load_next_addr", mem_addr, 3); chk("load_next_ctl", mem_control, 1);
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", instr_valid, 1); chk("stall_word", instr_word, 16'h0805);
            chk("stall_pc", instr_pc, 3); chk("stall_ctl", mem_control, 0);
            if (i < 4) cyc(1);
        end
        instr_ready = 1;
        cyc(1);
        instr_ready = 0;
        chk("release_ctl", mem_control, 1); chk("release_addr", mem_addr, 4);
        cyc(2);
        chk("op4_valid", instr_valid, 1);
        instr_ready = 1; redirect_valid = 1; redirect_pc = 51;
        cyc(1);
        instr_ready = 0; redirect_valid = 0;
        chk("to51_addr", mem_addr, 51);
        cyc(4);
        chk("jmpz_valid", instr_valid, 1); chk("jmpz_word", instr_word, 15360);
        chk("jmpz_imm", instr_imm, 32); chk("jmpz_pc", instr_pc, 51);
        instr_ready = 1; redirect_valid = 1; redirect_pc = 32;
        cyc(1);
        instr_ready = 0; redirect_valid = 0;
        chk("jmpz_redir_addr", mem_addr, 32); chk("jmpz_redir_valid", instr_valid, 0);
        cyc(3);
        redirect_valid = 1; redirect_pc = 10;
        cyc(1);
        redirect_valid = 0;
        chk("wimm_redir_addr", mem_addr, 10); chk("wimm_redir_ctl", mem_control, 1);
        chk("wimm_redir_valid", instr_valid, 0);
        cyc(1);
        chk("wimm_no_bundle", instr_valid, 0);
        cyc(1);
        chk("op10_valid", instr_valid, 1); chk("op10_word", instr_word, 16'h0805);
        chk("op10_pc", instr_pc, 10); chk("op10_imm", instr_imm, 0);
        instr_ready = 1; redirect_valid = 1; redirect_pc = 61;
        cyc(1);
        instr_ready = 0; redirect_valid = 0;
        chk("to61_addr", mem_addr, 61);
        cyc(2);
        chk("end_word", instr_word, 1024); chk("end_valid", instr_valid, 1);
        instr_ready = 1;
        cyc(1);
        instr_ready = 0; redirect_valid = 1; redirect_pc = 0;
        chk("halt_halted", halted, 1); chk("halt_ctl", mem_control, 0); chk("halt_valid", instr_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("halt_stay", halted, 1); chk("halt_stay_ctl", mem_control, 0);
        end
        redirect_valid = 0;
        reset = 1; run = 0; run_b = 1;
        #1;
        chk("reset_clears_halt", halted, 0);
        cyc(1);
        reset = 0;
        cyc(1);
        chk("b_req_ctl", mem_control_b, 1); chk("b_req_addr", mem_addr_b, 16'hFFFF);
        cyc(2);
        chk("b_valid", instr_valid_b, 1); chk("b_word", instr_word_b, 16'h0805); chk("b_pc", instr_pc_b, 16'hFFFF);
        instr_ready_b = 1;
        cyc(1);
        instr_ready_b = 0; run_b = 0;
        chk("b_wrap_addr", mem_addr_b, 0); chk("b_wrap_ctl", mem_control_b, 1);
        chk("idle_no_run_ctl", mem_control, 0); chk("idle_no_run_valid", instr_valid, 0);
        mem[61] = 16'h0805;
        run = 1;
        mpc = 16'd0;
        for (int n = 0; n < 60; n++) begin
            wt = 0;
            while (!instr_valid && wt < 20) begin
                cyc(1);
                wt++;
            end
            if (wt >= 20) begin
                chk("rand_timeout", {31'd0, instr_valid}, 1);
                break;
            end
            ew = mem[mpc];
            need = ew[13:10] == 4'd4 || ew[13:10] == 4'd15;
            ei = need ? mem[16'(mpc + 16'd1)] : 16'd0;
            chk("rand_word", instr_word, ew); chk("rand_imm", instr_imm, ei); chk("rand_pc", instr_pc, mpc);
            repeat ($urandom_range(0, 2)) begin
                cyc(1);
                chk("rand_hold_valid", instr_valid, 1); chk("rand_hold_word", instr_word, ew);
            end
            redir = $urandom_range(0, 3) == 0;
            rpc = 16'($urandom);
            instr_ready = 1; redirect_valid = redir; redirect_pc = rpc;
            cyc(1);
            instr_ready = 0; redirect_valid = 0;
            mpc = redir ? rpc : 16'(mpc + (need ? 16'd2 : 16'd1));
            chk("rand_next_addr", mem_addr, mpc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
